// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write arbiter.
// Holds the default index/data widths, the buffered-write entry layout and
// the arbiter FSM state encoding.
package rf_arb_pkg;

    localparam int unsigned RF_AW = 4;
    localparam int unsigned RF_DW = 32;

    // One buffered secondary write; valid drops when a younger primary write
    // to the same register makes it stale.
    typedef struct packed {
        logic               valid;
        logic [RF_AW-1:0]   dest;
        logic [RF_DW-1:0]   value;
    } rf_entry_t;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rf_wr_fifo.sv
// Secondary write buffer for the register-file write arbiter.
// Ports:
//   clk, rst                 clock, async active-high reset
//   push, push_dest/value    enqueue a new valid entry
//   pop                      dequeue the head (caller guarantees count != 0)
//   squash_en, squash_dest   invalidate every stored entry with this dest
//   src1, src2               read indices checked against valid entries
//   head_valid_c/dest_c/value_c  current head entry
//   count                    occupancy, squashed entries included
//   match1_c, match2_c       srcN hits a valid stored entry
// Entry widths come from rf_arb_pkg; AW/DW must match RF_AW/RF_DW.
module rf_wr_fifo
    import rf_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = RF_AW,
    parameter int unsigned DW    = RF_DW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [AW-1:0]                push_dest,
    input  logic [DW-1:0]                push_value,
    input  logic                         pop,
    input  logic                         squash_en,
    input  logic [AW-1:0]                squash_dest,
    input  logic [AW-1:0]                src1,
    input  logic [AW-1:0]                src2,
    output logic                         head_valid_c,
    output logic [AW-1:0]                head_dest_c,
    output logic [DW-1:0]                head_value_c,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         match1_c,
    output logic                         match2_c
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    rf_entry_t         mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    // Storage, pointers and occupancy. Popped slots are invalidated so the
    // match logic can scan all slots without consulting the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PW'(i)] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Squash first so that an entry written this cycle survives.
            if (squash_en) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (mem[PW'(i)].dest == squash_dest) begin
                        mem[PW'(i)].valid <= 1'b0;
                    end
                end
            end
            if (pop) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + PW'(1);
            end
            if (push) begin
                mem[wr_ptr] <= '{valid: 1'b1, dest: push_dest, value: push_value};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_valid_c = mem[rd_ptr].valid;
    assign head_dest_c  = mem[rd_ptr].dest;
    assign head_value_c = mem[rd_ptr].value;

    // Read-after-write hazard detect against live buffered entries.
    always_comb begin
        match1_c = 1'b0;
        match2_c = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (mem[PW'(i)].valid && (mem[PW'(i)].dest == src1)) match1_c = 1'b1;
            if (mem[PW'(i)].valid && (mem[PW'(i)].dest == src2)) match2_c = 1'b1;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register file's single write port between the WB stage
// (primary, always accepted) and buffered memory-return writes (secondary),
// with bounded wait for the secondary head and stale-write squashing.
// Ports:
//   clk, rst                          clock, async active-high reset
//   p_wb_en/dest/value                primary write request
//   s_valid/s_ready/s_dest/s_value    secondary write handshake
//   src1, src2 / hazard1, hazard2     decode read indices / buffered-RAW flags
//   pipe_stall                        freeze request while draining a starved head
//   rf_wb_en/dest/value               registered register-file write port
//   fifo_count                        buffer occupancy
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned DW       = RF_DW,
    parameter int unsigned AW       = RF_AW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     p_wb_en,
    input  logic [AW-1:0]            p_wb_dest,
    input  logic [DW-1:0]            p_wb_value,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [AW-1:0]            s_dest,
    input  logic [DW-1:0]            s_value,
    input  logic [AW-1:0]            src1,
    input  logic [AW-1:0]            src2,
    output logic                     hazard1,
    output logic                     hazard2,
    output logic                     pipe_stall,
    output logic                     rf_wb_en,
    output logic [AW-1:0]            rf_wb_dest,
    output logic [DW-1:0]            rf_wb_value,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned WW = $clog2(MAX_WAIT) + 1;

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [WW-1:0]     wait_q;
    logic [WW-1:0]     wait_d;

    logic              push;
    logic              pop;
    logic              grant_p;
    logic              grant_s;
    logic              head_present;
    logic              head_live;
    logic              head_dead;
    logic              head_valid;
    logic [AW-1:0]     head_dest;
    logic [DW-1:0]     head_value;

    assign s_ready = (fifo_count != CW'(DEPTH));
    assign push    = s_valid && s_ready;

    rf_wr_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_dest    (s_dest),
        .push_value   (s_value),
        .pop          (pop),
        .squash_en    (p_wb_en),
        .squash_dest  (p_wb_dest),
        .src1         (src1),
        .src2         (src2),
        .head_valid_c (head_valid),
        .head_dest_c  (head_dest),
        .head_value_c (head_value),
        .count        (fifo_count),
        .match1_c     (hazard1),
        .match2_c     (hazard2)
    );

    assign head_present = (fifo_count != CW'(0));
    assign head_live    = head_present && head_valid;
    assign head_dead    = head_present && !head_valid;

    // Next state, wait counter and grant selection. The grant rule is the
    // same in both states (primary first, then a live head); DRAIN only
    // differs in holding the pipeline stalled until the head leaves.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        grant_p = p_wb_en;
        grant_s = !p_wb_en && head_live;
        pop     = grant_s || head_dead;

        unique case (state_q)
            NORMAL: begin
                if (pop || !head_present) begin
                    wait_d = '0;
                end else begin
                    wait_d = wait_q + WW'(1);
                    if (wait_q == WW'(MAX_WAIT - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop || !head_present) begin
                    state_d = NORMAL;
                    wait_d  = '0;
                end
            end
            default: begin
                state_d = NORMAL;
                wait_d  = '0;
            end
        endcase
    end

    // FSM state and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NORMAL;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Registered write port and stall; dest/value hold when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_stall  <= 1'b0;
            rf_wb_en    <= 1'b0;
            rf_wb_dest  <= '0;
            rf_wb_value <= '0;
        end else begin
            pipe_stall <= (state_d == DRAIN);
            rf_wb_en   <= grant_p || grant_s;
            if (grant_p) begin
                rf_wb_dest  <= p_wb_dest;
                rf_wb_value <= p_wb_value;
            end else if (grant_s) begin
                rf_wb_dest  <= head_dest;
                rf_wb_value <= head_value;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter. Expected register-file
// writes are queued as stimulus is applied and popped whenever the DUT
// presents a write.
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst;
    logic        p_wb_en;
    logic [3:0]  p_wb_dest;
    logic [31:0] p_wb_value;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  s_dest;
    logic [31:0] s_value;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        hazard1;
    logic        hazard2;
    logic        pipe_stall;
    logic        rf_wb_en;
    logic [3:0]  rf_wb_dest;
    logic [31:0] rf_wb_value;
    logic [2:0]  fifo_count;

    typedef struct {
        logic [3:0]  d;
        logic [31:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    rf_write_arbiter #(
        .DEPTH    (4),
        .MAX_WAIT (8),
        .DW       (32),
        .AW       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .p_wb_en     (p_wb_en),
        .p_wb_dest   (p_wb_dest),
        .p_wb_value  (p_wb_value),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_dest      (s_dest),
        .s_value     (s_value),
        .src1        (src1),
        .src2        (src2),
        .hazard1     (hazard1),
        .hazard2     (hazard2),
        .pipe_stall  (pipe_stall),
        .rf_wb_en    (rf_wb_en),
        .rf_wb_dest  (rf_wb_dest),
        .rf_wb_value (rf_wb_value),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_wr(input logic [3:0] d, input logic [31:0] v);
        exp_t e;
        e.d = d;
        e.v = v;
        exp_q.push_back(e);
    endtask

    task automatic set_p(input logic en, input logic [3:0] d, input logic [31:0] v);
        p_wb_en    = en;
        p_wb_dest  = d;
        p_wb_value = v;
    endtask

    task automatic set_s(input logic en, input logic [3:0] d, input logic [31:0] v);
        s_valid = en;
        s_dest  = d;
        s_value = v;
    endtask

    // Advance one edge, then score any write the DUT presents.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (rf_wb_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(rf_wb_en), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("wb_dest", 64'(rf_wb_dest), 64'(e.d));
                check("wb_value", 64'(rf_wb_value), 64'(e.v));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        set_p(1'b0, 4'd0, 32'd0);
        set_s(1'b0, 4'd0, 32'd0);
        src1 = 4'd0;
        src2 = 4'd0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_en", 64'(rf_wb_en), 64'd0);
        check("rst_dest", 64'(rf_wb_dest), 64'd0);
        check("rst_value", 64'(rf_wb_value), 64'd0);
        check("rst_stall", 64'(pipe_stall), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_ready", 64'(s_ready), 64'd1);
        rst = 1'b0;
        tick();

        // Priority: primary now, secondary one edge later
        set_p(1'b1, 4'd2, 32'h11);
        set_s(1'b1, 4'd5, 32'h22);
        expect_wr(4'd2, 32'h11);
        expect_wr(4'd5, 32'h22);
        tick();
        check("prio_pending", 64'(exp_q.size()), 64'd1);
        check("prio_count1", 64'(fifo_count), 64'd1);
        set_p(1'b0, 4'd0, 32'd0);
        set_s(1'b0, 4'd0, 32'd0);
        tick();
        check("prio_pending2", 64'(exp_q.size()), 64'd0);
        check("prio_count0", 64'(fifo_count), 64'd0);
        tick();
        check("prio_idle", 64'(rf_wb_en), 64'd0);

        // Hazard on a buffered r3 until its grant edge
        src1 = 4'd4;
        src2 = 4'd3;
        set_p(1'b1, 4'd1, 32'h101);
        set_s(1'b1, 4'd3, 32'h33);
        expect_wr(4'd1, 32'h101);
        tick();
        check("haz2_set", 64'(hazard2), 64'd1);
        check("haz1_other", 64'(hazard1), 64'd0);
        set_s(1'b0, 4'd0, 32'd0);
        set_p(1'b1, 4'd1, 32'h102);
        expect_wr(4'd1, 32'h102);
        tick();
        check("haz2_held", 64'(hazard2), 64'd1);
        set_p(1'b0, 4'd0, 32'd0);
        expect_wr(4'd3, 32'h33);
        #1;
        check("haz2_pre_grant", 64'(hazard2), 64'd1);
        tick();
        check("haz2_clear", 64'(hazard2), 64'd0);
        check("haz_pending", 64'(exp_q.size()), 64'd0);

        // Squash: buffered r7=AA overtaken by primary r7=BB
        src1 = 4'd7;
        set_p(1'b1, 4'd1, 32'h201);
        set_s(1'b1, 4'd7, 32'hAA);
        expect_wr(4'd1, 32'h201);
        tick();
        check("sq_haz_set", 64'(hazard1), 64'd1);
        check("sq_count1", 64'(fifo_count), 64'd1);
        set_s(1'b0, 4'd0, 32'd0);
        set_p(1'b1, 4'd7, 32'hBB);
        expect_wr(4'd7, 32'hBB);
        tick();
        check("sq_haz_drop", 64'(hazard1), 64'd0);
        check("sq_count_kept", 64'(fifo_count), 64'd1);
        set_p(1'b0, 4'd0, 32'd0);
        tick();
        check("sq_no_write", 64'(rf_wb_en), 64'd0);
        check("sq_count0", 64'(fifo_count), 64'd0);
        check("sq_pending", 64'(exp_q.size()), 64'd0);

        // Full: four pushes behind a busy primary, fifth held off
        for (int i = 0; i < 4; i++) begin
            set_p(1'b1, 4'd1, 32'h300 + 32'(i));
            expect_wr(4'd1, 32'h300 + 32'(i));
            set_s(1'b1, 4'(8 + i), 32'h80 + 32'(i));
            tick();
        end
        check("full_count", 64'(fifo_count), 64'd4);
        check("full_ready", 64'(s_ready), 64'd0);
        set_p(1'b1, 4'd1, 32'h304);
        expect_wr(4'd1, 32'h304);
        set_s(1'b1, 4'd12, 32'hCC);
        tick();
        check("full_hold_count", 64'(fifo_count), 64'd4);
        check("full_hold_ready", 64'(s_ready), 64'd0);
        set_p(1'b0, 4'd0, 32'd0);
        for (int i = 0; i < 4; i++) expect_wr(4'(8 + i), 32'h80 + 32'(i));
        expect_wr(4'd12, 32'hCC);
        tick();
        check("full_pop_count", 64'(fifo_count), 64'd3);
        check("full_pop_ready", 64'(s_ready), 64'd1);
        tick();
        check("full_pushpop_count", 64'(fifo_count), 64'd3);
        set_s(1'b0, 4'd0, 32'd0);
        repeat (3) tick();
        check("full_drain_count", 64'(fifo_count), 64'd0);
        check("full_pending", 64'(exp_q.size()), 64'd0);

        // Starvation: head bypassed eight times, then drained
        set_p(1'b1, 4'd1, 32'h400);
        expect_wr(4'd1, 32'h400);
        set_s(1'b1, 4'd6, 32'h66);
        tick();
        set_s(1'b0, 4'd0, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            set_p(1'b1, 4'd1, 32'h400 + 32'(k));
            expect_wr(4'd1, 32'h400 + 32'(k));
            tick();
            if (k == 7) check("stall_before", 64'(pipe_stall), 64'd0);
            if (k == 8) check("stall_set", 64'(pipe_stall), 64'd1);
        end
        set_p(1'b1, 4'd1, 32'h409);
        expect_wr(4'd1, 32'h409);
        tick();
        check("drain_primary_stall", 64'(pipe_stall), 64'd1);
        check("drain_primary_count", 64'(fifo_count), 64'd1);
        set_p(1'b0, 4'd0, 32'd0);
        expect_wr(4'd6, 32'h66);
        tick();
        check("drain_exit_stall", 64'(pipe_stall), 64'd0);
        check("drain_count", 64'(fifo_count), 64'd0);
        check("drain_pending", 64'(exp_q.size()), 64'd0);

        // Reset mid-stream with three entries buffered
        for (int i = 0; i < 3; i++) begin
            set_p(1'b1, 4'd1, 32'h500 + 32'(i));
            expect_wr(4'd1, 32'h500 + 32'(i));
            set_s(1'b1, 4'(9 + i), 32'h90 + 32'(i));
            tick();
        end
        set_s(1'b0, 4'd0, 32'd0);
        set_p(1'b1, 4'd2, 32'h5FF);
        src1 = 4'd9;
        #1;
        check("mid_count3", 64'(fifo_count), 64'd3);
        check("mid_haz_pre", 64'(hazard1), 64'd1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("mid_rst_en", 64'(rf_wb_en), 64'd0);
        check("mid_rst_count", 64'(fifo_count), 64'd0);
        check("mid_rst_ready", 64'(s_ready), 64'd1);
        check("mid_rst_stall", 64'(pipe_stall), 64'd0);
        for (int i = 0; i < 16; i++) begin
            src1 = 4'(i);
            #1;
            check("mid_rst_haz1", 64'(hazard1), 64'd0);
        end
        tick();
        set_p(1'b0, 4'd0, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_en", 64'(rf_wb_en), 64'd0);
        check("post_rst_count", 64'(fifo_count), 64'd0);

        // Bounded wait for anything still expected
        for (int n = 0; n < 10 && exp_q.size() != 0; n++) tick();
        check("final_pending", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port between the pipeline write-back stage (primary) and the multi-cycle memory-return unit (secondary). Secondary writes are buffered in a small FIFO, and the block enforces a bounded wait for them. It squashes buffered writes made stale by a younger primary write to the same register. It also flags read-after-write hazards against buffered entries to the hazard unit. It sits between the WB stage and the register file write port.

## Interface
- DEPTH, 4: secondary FIFO entries; power of 2, at least 2.
- MAX_WAIT, 8: cycles a valid FIFO head may be bypassed before starvation handling.
- DW, 32: data width.
- AW, 4: register index width.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- p_wb_en  in  1  primary write request; always accepted, no ready.
- p_wb_dest  in  AW  primary destination register.
- p_wb_value  in  DW  primary write data.
- s_valid  in  1  secondary write request.
- s_ready  out  1  secondary accept; equals (count != DEPTH).
- s_dest  in  AW  secondary destination register.
- s_value  in  DW  secondary write data.
- src1, src2  in  AW  decode-stage read indices.
- hazard1, hazard2  out  1  srcN matches dest of a valid (unsquashed) FIFO entry; combinational.
- pipe_stall  out  1  registered; asks the pipeline to freeze and bubble WB.
- rf_wb_en  out  1  registered write enable to the register file.
- rf_wb_dest  out  AW  registered write index.
- rf_wb_value  out  DW  registered write data.
- fifo_count  out  log2(DEPTH)+1  occupancy, including squashed entries.

## Operation
- FIFO entry contents: {valid, dest, value}. Push when s_valid && s_ready, with valid=1.
- Squash rule: an accepted primary write clears valid on every stored entry whose dest equals p_wb_dest. An entry pushed in the same cycle is not squashed.
- Head disposal:
  - A squashed head (valid=0) is popped with no write, in any cycle, including cycles with a primary write.
  - At most one pop per cycle.
- FSM, 2 states:
  - NORMAL:
    - If p_wb_en, grant primary.
    - Else if the head is valid, grant the head and pop it.
    - wait_cnt increments each cycle the head is valid and not popped. wait_cnt clears on any pop or when the FIFO is empty.
    - When wait_cnt reaches MAX_WAIT-1 with the head still not popped, go to DRAIN.
  - DRAIN:
    - pipe_stall=1.
    - Primary keeps priority if p_wb_en is still asserted, to cover in-flight writes.
    - The first cycle without p_wb_en grants the valid head.
    - After that pop, or a squash-pop of the head, return to NORMAL and clear wait_cnt.
- Grant action: the next edge loads rf_wb_en=1 and rf_wb_dest/value from the winner. With no grant, rf_wb_en=0 and dest/value hold.
- hazard1/hazard2 compare against valid entries only. The output register is excluded, because the register file write completes within the cycle.

## Timing
- Reset values: rf_wb_en=0, rf_wb_dest=0, rf_wb_value=0, pipe_stall=0, fifo_count=0, wait_cnt=0, state NORMAL, all entries invalid. s_ready=1 during and after reset.
- Primary latency: p_wb_en sampled at edge N gives rf_wb_en high in cycle N+1.
- Secondary minimum latency: pushed at edge N, earliest grant at edge N+1, rf_wb_en high in cycle N+2.
- Full boundary:
  - A push and a pop in the same cycle while full is impossible, because s_ready=0 when count==DEPTH (no pass-through).
  - Push and pop together when not full leave count unchanged.
- Pointers wrap modulo DEPTH. count disambiguates full from empty.
- pipe_stall rises in the cycle after the DRAIN entry edge and falls in the cycle after the DRAIN exit edge.
- Reset mid-operation discards all buffered entries and any pending output write.

## Structure
- Package rf_arb_pkg holds the AW/DW defaults, the entry struct {valid, dest, value}, and the state enum {NORMAL, DRAIN}.
- Sub-module rf_wr_fifo holds storage, pointers, count, the per-entry squash compare against an input dest, and the two src-match outputs.
- rf_write_arbiter holds the FSM, wait counter, grant mux, and output registers.

## Test plan
- Reset: assert rst mid-stream with 3 entries buffered -> rf_wb_en=0, fifo_count=0, s_ready=1, hazard1=0 for all src.
- Priority: p_wb_en r2=0x11 and s_valid r5=0x22 in the same cycle -> r2 written in cycle N+1, r5 written in cycle N+2.
- Full:
  - 4 secondary pushes with primary busy -> s_ready=0 and fifo_count=4.
  - A fifth s_valid is held until the first pop.
- Starvation (MAX_WAIT=8): p_wb_en held continuously with 1 entry buffered -> pipe_stall=1 after 8 bypassed cycles.
  - Drop p_wb_en -> the entry is written and pipe_stall returns to 0.
- Squash: buffered r7=0xAA, then primary r7=0xBB -> only 0xBB written, fifo_count decrements with no rf_wb_en, hazard1 for src1=7 drops after the squash.
- Hazard: buffered r3 entry, src2=3 -> hazard2=1 until the cycle after the r3 grant edge.
